// File: rtl/lfsr_pkg.sv
// Shared constants and state encoding for the 5-bit PRBS checker.
// Generator poly x^5+x^2+1, period 31.
package lfsr_pkg;

  localparam int LFSR_W = 5;
  localparam int TAP_A  = 0;
  localparam int TAP_B  = 2;

  localparam logic [LFSR_W-1:0] RESET_SEED = 5'h1;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    SEARCH = 2'd1,
    LOCKED = 2'd2
  } chk_state_e;

endpackage

// File: rtl/lfsr_prbs_checker_sat_counter.sv
// Saturating event counter with synchronous clear.
// Clear wins over a coincident increment.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] q
);

  logic [CNT_W-1:0] q_q;
  logic [CNT_W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc && (q_q != '1)) begin
      q_d = q_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/lfsr_prbs_checker.sv
// Self-synchronising PRBS5 checker: FILL -> SEARCH -> LOCKED flywheel.
// Define LFSR_CHK_STATS_EN to build the err/bit statistics counters.
module lfsr_prbs_checker
  import lfsr_pkg::*;
#(
  parameter int LOCK_THRESH = 10,
  parameter int LOSS_THRESH = 3,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic             clr,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] bit_count,
  output logic [1:0]       state_o
);

  localparam int MW = $clog2(LOCK_THRESH + 1);
  localparam int LW = $clog2(LOSS_THRESH + 1);

  chk_state_e        state_q, state_d;
  logic [LFSR_W-1:0] hist_q, hist_d;
  logic [2:0]        fill_q, fill_d;
  logic [MW-1:0]     match_q, match_d;
  logic [LW-1:0]     miss_q, miss_d;
  logic              err_q, err_d;
  logic              bit_inc;
  logic              pred;

  assign pred = hist_q[TAP_A] ^ hist_q[TAP_B];

  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    match_d = match_q;
    miss_d  = miss_q;
    err_d   = 1'b0;
    bit_inc = 1'b0;
    if (din_valid) begin
      unique case (state_q)
        FILL: begin
          hist_d = {din, hist_q[LFSR_W-1:1]};
          if (fill_q == 3'(LFSR_W - 1)) begin
            fill_d  = '0;
            match_d = '0;
            state_d = SEARCH;
          end else begin
            fill_d = fill_q + 3'd1;
          end
        end
        SEARCH: begin
          hist_d = {din, hist_q[LFSR_W-1:1]};
          // all-zero history is the LFSR lock-up state; never trust it
          if ((hist_q == '0) || (din != pred)) begin
            match_d = '0;
          end else if (match_q == MW'(LOCK_THRESH - 1)) begin
            match_d = '0;
            miss_d  = '0;
            state_d = LOCKED;
          end else begin
            match_d = match_q + MW'(1);
          end
        end
        LOCKED: begin
          bit_inc = 1'b1;
          hist_d  = {pred, hist_q[LFSR_W-1:1]};
          if (din != pred) begin
            err_d = 1'b1;
            if (miss_q == LW'(LOSS_THRESH - 1)) begin
              state_d = FILL;
              hist_d  = '0;
              fill_d  = '0;
              match_d = '0;
              miss_d  = '0;
            end else begin
              miss_d = miss_q + LW'(1);
            end
          end else begin
            miss_d = '0;
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FILL;
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= '0;
      miss_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      match_q <= match_d;
      miss_q  <= miss_d;
      err_q   <= err_d;
    end
  end

  assign locked  = (state_q == LOCKED);
  assign err     = err_q;
  assign state_o = state_q;

`ifdef LFSR_CHK_STATS_EN
  sat_counter #(
    .CNT_W(CNT_W)
  ) u_err_cnt (
    .clk(clk),
    .rst(rst),
    .inc(err_d),
    .clr(clr),
    .q  (err_count)
  );

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_bit_cnt (
    .clk(clk),
    .rst(rst),
    .inc(bit_inc),
    .clr(clr),
    .q  (bit_count)
  );
`else
  logic unused_stats;
  assign unused_stats = clr ^ bit_inc;
  assign err_count    = '0;
  assign bit_count    = '0;
`endif

endmodule
